// File: rtl/rtc_bus_cycle_ctrl_if.sv
// Request/strobe bundle between the RTC bus-cycle sequencer and its neighbours.
interface rtc_bus_cycle_ctrl_if;
  logic       in_start;
  logic       in_rw;
  logic [7:0] in_addr;
  logic [7:0] in_wdata;
  logic [7:0] in_rdata;
  logic [7:0] out_addr;
  logic [7:0] out_wdata;
  logic [7:0] out_rdata;
  logic       out_flag_dato;
  logic       out_direccion_dato;
  logic       out_controlador_dato;
  logic       out_wr;
  logic       cs_n;
  logic       ad_n;
  logic       wr_n;
  logic       rd_n;
  logic       out_busy;
  logic       out_done;

  modport master (
    output in_start, in_rw, in_addr, in_wdata, in_rdata,
    input  out_addr, out_wdata, out_rdata, out_flag_dato, out_direccion_dato,
    input  out_controlador_dato, out_wr, cs_n, ad_n, wr_n, rd_n, out_busy, out_done
  );

  modport slave (
    input  in_start, in_rw, in_addr, in_wdata, in_rdata,
    output out_addr, out_wdata, out_rdata, out_flag_dato, out_direccion_dato,
    output out_controlador_dato, out_wr, cs_n, ad_n, wr_n, rd_n, out_busy, out_done
  );
endinterface

// File: rtl/rtc_bus_cycle_ctrl.sv
// Address/data bus-cycle sequencer for the multiplexed RTC port.
// Define RTC_BUS_QUEUE_EN to add a one-entry pending request register.
module rtc_bus_cycle_ctrl #(
  parameter int unsigned T_SU  = 2,
  parameter int unsigned T_PW  = 4,
  parameter int unsigned T_H   = 2,
  parameter int unsigned T_GAP = 3
) (
  input logic                 clk,
  input logic                 reset,
  rtc_bus_cycle_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, A_SU, A_PW, A_H, GAP, D_SU, D_PW, D_H, DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       start_q, start_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       cs_n_q, cs_n_d, ad_n_q, ad_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic       flag_q, flag_d, dir_q, dir_d, ctrl_q, ctrl_d, owr_q, owr_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic       accept;

`ifdef RTC_BUS_QUEUE_EN
  logic       pend_q, pend_d;
  logic       pend_rw_q, pend_rw_d;
  logic [7:0] pend_addr_q, pend_addr_d;
  logic [7:0] pend_wdata_q, pend_wdata_d;
`endif

  function automatic logic [3:0] load_val(input state_e s);
    case (s)
      A_SU, D_SU: return 4'(T_SU - 1);
      A_PW, D_PW: return 4'(T_PW - 1);
      A_H,  D_H:  return 4'(T_H - 1);
      GAP:        return 4'(T_GAP - 1);
      default:    return '0;
    endcase
  endfunction

  // Requests are latched in IDLE and launched one cycle later, so A_SU
  // starts on the edge after the sampling edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    accept  = (state_q == IDLE) && !start_q && bus.in_start;

    if (accept) begin
      start_d = 1'b1;
      rw_d    = bus.in_rw;
      addr_d  = bus.in_addr;
      wdata_d = bus.in_wdata;
    end

`ifdef RTC_BUS_QUEUE_EN
    pend_d       = pend_q;
    pend_rw_d    = pend_rw_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    if (busy_q && (state_q != DONE) && !pend_q && bus.in_start) begin
      pend_d       = 1'b1;
      pend_rw_d    = bus.in_rw;
      pend_addr_d  = bus.in_addr;
      pend_wdata_d = bus.in_wdata;
    end
`endif

    unique case (state_q)
      IDLE: if (start_q) state_d = A_SU;
      A_SU: if (cnt_q == '0) state_d = A_PW;
      A_PW: if (cnt_q == '0) state_d = A_H;
      A_H:  if (cnt_q == '0) state_d = GAP;
      GAP:  if (cnt_q == '0) state_d = D_SU;
      D_SU: if (cnt_q == '0) state_d = D_PW;
      D_PW: if (cnt_q == '0) begin
        state_d = D_H;
        if (!rw_q) rdata_d = bus.in_rdata;
      end
      D_H:  if (cnt_q == '0) state_d = DONE;
      DONE: begin
        state_d = IDLE;
`ifdef RTC_BUS_QUEUE_EN
        if (pend_q) begin
          state_d = A_SU;
          rw_d    = pend_rw_q;
          addr_d  = pend_addr_q;
          wdata_d = pend_wdata_q;
          pend_d  = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = load_val(state_d);
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  // Pin/flag values are decoded from the next state so they register in lock-step with it.
  always_comb begin
    cs_n_d = 1'b1;
    ad_n_d = 1'b1;
    wr_n_d = 1'b1;
    rd_n_d = 1'b1;
    flag_d = 1'b0;
    dir_d  = 1'b0;
    ctrl_d = 1'b0;
    owr_d  = 1'b0;
    unique case (state_d)
      A_SU, A_PW, A_H: begin
        cs_n_d = 1'b0;
        ad_n_d = 1'b0;
        flag_d = 1'b1;
        ctrl_d = 1'b1;
        wr_n_d = (state_d != A_PW);
      end
      GAP: ctrl_d = 1'b1;
      D_SU, D_PW, D_H: begin
        cs_n_d = 1'b0;
        flag_d = 1'b1;
        dir_d  = 1'b1;
        ctrl_d = rw_d;
        owr_d  = !rw_d;
        if (state_d == D_PW) begin
          wr_n_d = !rw_d;
          rd_n_d = rw_d;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE) || start_d;
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cs_n_q  <= 1'b1;
      ad_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      flag_q  <= 1'b0;
      dir_q   <= 1'b0;
      ctrl_q  <= 1'b0;
      owr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cs_n_q  <= cs_n_d;
      ad_n_q  <= ad_n_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      flag_q  <= flag_d;
      dir_q   <= dir_d;
      ctrl_q  <= ctrl_d;
      owr_q   <= owr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef RTC_BUS_QUEUE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q       <= 1'b0;
      pend_rw_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
    end else begin
      pend_q       <= pend_d;
      pend_rw_q    <= pend_rw_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
    end
  end
`endif

  assign bus.out_addr             = addr_q;
  assign bus.out_wdata            = wdata_q;
  assign bus.out_rdata            = rdata_q;
  assign bus.out_flag_dato        = flag_q;
  assign bus.out_direccion_dato   = dir_q;
  assign bus.out_controlador_dato = ctrl_q;
  assign bus.out_wr               = owr_q;
  assign bus.cs_n                 = cs_n_q;
  assign bus.ad_n                 = ad_n_q;
  assign bus.wr_n                 = wr_n_q;
  assign bus.rd_n                 = rd_n_q;
  assign bus.out_busy             = busy_q;
  assign bus.out_done             = done_q;

endmodule

// File: tb/tb_rtc_bus_cycle_ctrl.sv
// Scoreboard bench for rtc_bus_cycle_ctrl; expectations follow RTC_BUS_QUEUE_EN if defined.
`timescale 1ns/1ps
module tb_rtc_bus_cycle_ctrl;

  localparam int PW0 = 4;
  localparam int GAP0 = 3;
  localparam int L0 = 2 * (2 + 4 + 2) + 3 + 1;
  localparam int L1 = 2 * (1 + 1 + 1) + 1 + 1;
`ifdef RTC_BUS_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rtc_bus_cycle_ctrl_if bus0 ();
  rtc_bus_cycle_ctrl_if bus1 ();

  rtc_bus_cycle_ctrl dut0 (.clk(clk), .reset(reset), .bus(bus0));
  rtc_bus_cycle_ctrl #(.T_SU(1), .T_PW(1), .T_H(1), .T_GAP(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // The RTC answers a read with a byte derived from the address on the bus.
  assign bus0.in_rdata = bus0.out_addr ^ 8'h65;
  assign bus1.in_rdata = bus1.out_addr ^ 8'h65;

  typedef struct {
    int         cyc;
    bit         rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         last_done = -100;
  int         pend_done = 0;
  bit         pend = 1'b0;
  logic [7:0] last_rd = 8'h00;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push(input int c, input bit rw, input logic [7:0] a, input logic [7:0] w);
    exp_t e;
    if (!rw) last_rd = a ^ 8'h65;
    e.cyc = c; e.rw = rw; e.addr = a; e.wdata = w; e.rdata = last_rd;
    sb.push_back(e);
  endfunction

  // Reference: a request sampled at edge k finishes L0 edges later; the edge right after
  // a done is deaf; with the queue, one request arriving mid-transaction chains on.
  function automatic void model_edge(input int k, input bit st, input bit rw,
                                     input logic [7:0] a, input logic [7:0] w);
    if (k == last_done + 1) begin
      if (pend) begin
        last_done = pend_done;
        pend = 1'b0;
      end
    end else if (st) begin
      if (k >= last_done + 2) begin
        last_done = k + L0;
        push(k + L0, rw, a, w);
      end else if (QEN && !pend) begin
        pend = 1'b1;
        pend_done = last_done + L0;
        push(pend_done, rw, a, w);
      end
    end
  endfunction

  task automatic step(input bit st, input bit rw, input logic [7:0] a, input logic [7:0] w, input bit r);
    int k;
    @(posedge clk);
    #1;
    k = cyc + 1;
    if (r) begin
      sb.delete();
      last_done = -100;
      pend = 1'b0;
      last_rd = 8'h00;
    end else begin
      model_edge(k, st, rw, a, w);
    end
    reset = r;
    bus0.in_start = st;
    bus0.in_rw = rw;
    bus0.in_addr = a;
    bus0.in_wdata = w;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  // Monitor: per-transaction strobe accounting, compared when done pulses.
  initial begin : monitor
    int   aw, dw, dr, drf, gap;
    bit   seen;
    exp_t e;
    aw = 0; dw = 0; dr = 0; drf = 0; gap = 0; seen = 1'b0;
    forever begin
      @(negedge clk);
      if (bus1.out_flag_dato)
        check("p1_flag_code", int'({bus1.out_controlador_dato, bus1.out_direccion_dato} != 2'b00), 1);
      if (reset) begin
        aw = 0; dw = 0; dr = 0; drf = 0; gap = 0; seen = 1'b0;
      end else begin
        if (bus0.out_flag_dato)
          check("flag_code", int'({bus0.out_controlador_dato, bus0.out_direccion_dato} != 2'b00), 1);
        if (bus0.out_done) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got done pulse, required none (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("rdata", int'(bus0.out_rdata), int'(e.rdata));
            check("addr_wr_cycles", aw, PW0);
            check("data_wr_cycles", dw, e.rw ? PW0 : 0);
            check("data_rd_cycles", dr, e.rw ? 0 : PW0);
            check("rd_flag_cycles", drf, dr);
            check("gap_cycles", gap, GAP0);
            check("done_strobes", int'({bus0.cs_n, bus0.wr_n, bus0.rd_n}), 7);
          end
          aw = 0; dw = 0; dr = 0; drf = 0; gap = 0; seen = 1'b0;
        end else begin
          if (!bus0.wr_n && !bus0.ad_n) aw++;
          if (!bus0.wr_n && bus0.ad_n && bus0.out_controlador_dato) dw++;
          if (!bus0.rd_n) begin
            dr++;
            if (bus0.out_wr && !bus0.out_controlador_dato && bus0.out_direccion_dato) drf++;
          end
          if (!bus0.cs_n) begin
            seen = 1'b1;
            if (sb.size() > 0) begin
              check("out_addr", int'(bus0.out_addr), int'(sb[0].addr));
              if (sb[0].rw) check("out_wdata", int'(bus0.out_wdata), int'(sb[0].wdata));
            end
          end else if (seen) begin
            gap++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int         n, k1;
    bit         got;
    logic [7:0] exp1;
    bus0.in_start = 1'b0; bus0.in_rw = 1'b0; bus0.in_addr = '0; bus0.in_wdata = '0;
    bus1.in_start = 1'b0; bus1.in_rw = 1'b0; bus1.in_addr = '0; bus1.in_wdata = '0;

    repeat (3) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    check("rst_strobes", int'({bus0.cs_n, bus0.ad_n, bus0.wr_n, bus0.rd_n}), 'hF);
    check("rst_flags", int'({bus0.out_flag_dato, bus0.out_direccion_dato, bus0.out_controlador_dato,
                             bus0.out_wr, bus0.out_busy, bus0.out_done}), 0);
    check("rst_data", int'({bus0.out_addr, bus0.out_wdata, bus0.out_rdata}), 0);

    // Write then read at default timing
    step(1'b1, 1'b1, 8'h21, 8'h59, 1'b0);
    idle(25);
    step(1'b1, 1'b0, 8'h22, 8'h00, 1'b0);
    idle(25);
    @(negedge clk);
    check("rdata_held", int'(bus0.out_rdata), 'h47);

    // Minimum-timing instance
    bus1.in_start = 1'b1; bus1.in_rw = 1'b0; bus1.in_addr = 8'h3C;
    k1 = cyc + 1;
    exp1 = 8'h3C;
    exp1 = exp1 ^ 8'h65;
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    bus1.in_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus1.out_done) begin
        got = 1'b1;
        check("p1_done_cycle", cyc, k1 + L1);
        check("p1_rdata", int'(bus1.out_rdata), int'(exp1));
      end
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL p1_timeout: got no done within 20 cycles, required done at cycle %0d", k1 + L1);
    end
    idle(4);

    // Back-to-back: second request five cycles after the first
    step(1'b1, 1'b1, 8'h30, 8'hA1, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 8'h44, 8'h00, 1'b0);
    idle(50);

    // Reset while in the data setup phase
    step(1'b1, 1'b1, 8'h55, 8'h66, 1'b0);
    idle(12);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    check("mid_dsu_pins", int'({bus0.cs_n, bus0.ad_n, bus0.out_busy}), 'b011);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    check("abort_strobes", int'({bus0.cs_n, bus0.ad_n, bus0.wr_n, bus0.rd_n}), 'hF);
    check("abort_busy_done", int'({bus0.out_busy, bus0.out_done}), 0);
    check("abort_rdata", int'(bus0.out_rdata), 0);
    idle(30);

    // Randomised traffic
    repeat (500) begin
      step($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b0);
    end

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      idle(1);
      n++;
    end
    idle(3);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_bus_cycle_ctrl.md
# rtc_bus_cycle_ctrl

Bus-cycle sequencer for the multiplexed address/data RTC port. It sits directly upstream of the RTC bus read/write multiplexer. For each accepted request it generates the chip strobes (`cs_n`, `ad_n`, `wr_n`, `rd_n`) and the mux control flags in lock-step. Each transaction is an address-write phase followed by a data-write or data-read phase. On reads it captures the byte the mux returns and hands it to the register bank with a one-cycle `done` pulse.

## Interface
Parameters:
- `T_SU`, 2, setup cycles per phase before the strobe asserts (valid range 1..15)
- `T_PW`, 4, strobe low cycles per phase (1..15)
- `T_H`, 2, hold cycles per phase after the strobe deasserts (1..15)
- `T_GAP`, 3, cycles with `cs_n` high between the address and data phases (1..15)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `in_start`  in  1  request strobe; sampled every cycle
- `in_rw`  in  1  1 = write, 0 = read; sampled with `in_start`
- `in_addr`  in  8  RTC register address; sampled with `in_start`
- `in_wdata`  in  8  write data; sampled with `in_start`
- `in_rdata`  in  8  read byte from the mux (`out_reg_dato` path)
- `out_addr`  out  8  latched address, fed to the mux RAM-address input
- `out_wdata`  out  8  latched write data, fed to the mux data input
- `out_flag_dato`  out  1  mux active window
- `out_direccion_dato`  out  1  0 = address phase, 1 = data phase
- `out_controlador_dato`  out  1  1 = mux drives the bus, 0 = mux reads the bus
- `out_wr`  out  1  1 = bus released for the RTC to drive (read data phase only)
- `cs_n`, `ad_n`, `wr_n`, `rd_n`  out  1 each  RTC pins, active-low
- `out_busy`  out  1  transaction in progress
- `out_done`  out  1  one-cycle completion pulse
- `out_rdata`  out  8  captured read byte; held until the next read completes

## Operation
Reset values:
- `cs_n`, `wr_n`, `rd_n`, `ad_n` = 1
- all flags, `out_busy`, `out_done` = 0
- `out_addr`, `out_wdata`, `out_rdata` = 0x00

FSM states: IDLE, A_SU, A_PW, A_H, GAP, D_SU, D_PW, D_H, DONE. A 4-bit down-counter loads on each state entry.
- IDLE: when `in_start`=1, latch rw/addr/wdata and go to A_SU. `out_busy` rises on the same edge.
- Address phase (A_SU, A_PW, A_H):
  - `cs_n`=0, `ad_n`=0, `out_flag_dato`=1, `out_direccion_dato`=0, `out_controlador_dato`=1, `out_wr`=0.
  - `wr_n`=0 only in A_PW.
- GAP: `cs_n`=1, `out_flag_dato`=0, for T_GAP cycles.
- Data phase (D_SU, D_PW, D_H):
  - `cs_n`=0, `ad_n`=1, `out_flag_dato`=1, `out_direccion_dato`=1.
  - Write: `out_controlador_dato`=1, `out_wr`=0, `wr_n`=0 in D_PW.
  - Read: `out_controlador_dato`=0, `out_wr`=1, `rd_n`=0 in D_PW. `in_rdata` is latched into `out_rdata` on the last D_PW cycle.
- DONE: one cycle with `out_done`=1 and all strobes idle. Next state is IDLE; `out_busy` falls on that edge.
- The code pair {`out_controlador_dato`, `out_direccion_dato`} = 00 is never produced.
- `in_start` while busy: ignored (see Configuration).
- All pin and flag outputs are registered; no combinational path from inputs to outputs.

## Timing
- `in_start` sampled at edge N: A_SU is active from N+1.
- `out_done` high for exactly one cycle, N + 2·(T_SU+T_PW+T_H) + T_GAP + 1 cycles after N. With defaults this is N+20.
- Strobe edges never coincide with `cs_n` or `ad_n` edges: setup and hold are each at least 1 cycle.
- `reset` mid-transaction: on the next edge all strobes deassert, the FSM returns to IDLE, `out_done` is not pulsed, and `out_rdata` is cleared.
- A new `in_start` in the DONE cycle is ignored. IDLE accepts again one cycle later.

## Configuration
Macro `RTC_BUS_QUEUE_EN`.
- Defined: adds a one-entry pending request register.
  - An `in_start` arriving while busy is stored if the register is empty.
  - After DONE the FSM enters A_SU directly, skipping IDLE; `out_busy` stays high.
  - A further `in_start` while the register is full is dropped.
  - Reset clears the register.
- Undefined: no pending register. `in_start` while busy is dropped.

## Test plan
- Write, defaults: `in_start`, rw=1, addr=0x21, wdata=0x59.
  - `wr_n` low 4 cycles with `ad_n`=0 and `out_addr`=0x21.
  - `cs_n` high 3 cycles (GAP).
  - `wr_n` low 4 cycles with `ad_n`=1 and `out_controlador_dato`=1.
  - `out_done` at N+20.
- Read: rw=0, addr=0x22; bench drives `in_rdata`=0x47 during D_PW.
  - `rd_n` low 4 cycles with `out_wr`=1 and flags = 01.
  - `out_rdata`=0x47 at done and held afterwards.
- Back-to-back: second `in_start` at N+5.
  - Macro off: ignored; only one `done`.
  - Macro on: second transaction starts at N+21, `out_busy` stays continuously high, and two `done` pulses are seen, at N+20 and N+40.
- Reset at N+12 during D_SU: next edge gives all strobes high, `out_busy`=0, no `done`, `out_rdata`=0x00.
- Parameters T_SU=T_PW=T_H=T_GAP=1: `done` at N+8. Flag code 00 is never observed (assertion over whole run).
